// File: rtl/seq_bin2bcd_multi.sv
// Multi-channel sequential binary-to-BCD converter (double dabble, one bit per clock)
// with valid/ready handshakes, per-channel overflow and optional saturation.
module seq_bin2bcd_multi #(
   parameter int unsigned WIDTH    = 6,
   parameter int unsigned DIGITS   = 2,
   parameter int unsigned NCH      = 4,
   parameter int unsigned SATURATE = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NCH*WIDTH-1:0]     bin_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NCH*DIGITS*4-1:0]  bcd_out,
   output logic [NCH-1:0]           ovf,
   output logic                     busy
);

   localparam int unsigned DW   = DIGITS * 4;
   localparam int unsigned SW   = DW + WIDTH;
   localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned CNTW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t                 state;
   logic [NCH*WIDTH-1:0]   bin_q;
   logic [SW-1:0]          sr;
   logic [CHW-1:0]         ch;
   logic [CNTW-1:0]        cnt;
   logic                   flag;

   logic [DW-1:0]          corr;
   logic [SW-1:0]          sr_shift;
   logic                   flag_nxt;
   logic [DW-1:0]          slot_val;
   logic                   last_bit;
   logic [CHW-1:0]         ch_inc;
   logic [WIDTH-1:0]       chan_nxt;

   // Add-3 correction of every digit, shift, overflow capture and next-channel select
   always_comb begin
      corr = '0;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (sr[WIDTH + 4*d +: 4] >= 4'd5)
            corr[4*d +: 4] = sr[WIDTH + 4*d +: 4] + 4'd3;
         else
            corr[4*d +: 4] = sr[WIDTH + 4*d +: 4];
      end
      sr_shift = {corr[DW-2:0], sr[WIDTH-1:0], 1'b0};
      // A set MSB in the top corrected digit is a carry lost past the last digit
      flag_nxt = flag | corr[DW-1];
      slot_val = ((SATURATE != 0) && flag_nxt) ? {DIGITS{4'h9}} : sr_shift[SW-1:WIDTH];
      last_bit = (cnt == CNTW'(WIDTH - 1));
      ch_inc   = ch + CHW'(1);
      chan_nxt = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         if (CHW'(c) == ch_inc)
            chan_nxt = bin_q[c*WIDTH +: WIDTH];
      end
   end

   // Control FSM and datapath registers; all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         bcd_out   <= '0;
         ovf       <= '0;
         bin_q     <= '0;
         sr        <= '0;
         ch        <= '0;
         cnt       <= '0;
         flag      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  bin_q    <= bin_in;
                  ch       <= '0;
                  cnt      <= '0;
                  sr       <= {DW'(0), bin_in[WIDTH-1:0]};
                  flag     <= 1'b0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= CONV;
               end
            end
            CONV: begin
               sr   <= sr_shift;
               flag <= flag_nxt;
               cnt  <= cnt + CNTW'(1);
               if (last_bit) begin
                  for (int unsigned c = 0; c < NCH; c++) begin
                     if (CHW'(c) == ch) begin
                        bcd_out[c*DW +: DW] <= slot_val;
                        ovf[c]              <= flag_nxt;
                     end
                  end
                  cnt  <= '0;
                  flag <= 1'b0;
                  // Next channel loads on the same edge so there is no bubble
                  if (ch != CHW'(NCH - 1)) begin
                     ch <= ch_inc;
                     sr <= {DW'(0), chan_nxt};
                  end else begin
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_bin2bcd_multi.sv
// Bench for seq_bin2bcd_multi: directed checks on the default build and two overflow
// builds, plus randomized transactions on several parameter sets against a decimal model.
module tb_seq_bin2bcd_multi;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_tests  = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;
   int unsigned done_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Decimal reference: value mod 10^digits (or all 9s when saturating), as BCD nibbles
   function automatic logic [63:0] ref_chan(input longint unsigned v, input int unsigned digits,
                                            input bit sat);
      longint unsigned lim = 1;
      longint unsigned m;
      logic [63:0] r = '0;
      for (int i = 0; i < int'(digits); i++) lim = lim * 10;
      if (sat && v >= lim) m = lim - 1;
      else m = v % lim;
      for (int i = 0; i < int'(digits); i++) begin
         r = r | (64'(m % 10) << (4*i));
         m = m / 10;
      end
      return r;
   endfunction

   function automatic logic [31:0] exp_default(input logic [23:0] b);
      logic [31:0] r = '0;
      logic [63:0] one;
      for (int c = 0; c < 4; c++) begin
         one = ref_chan(64'(b[c*6 +: 6]), 2, 1'b0);
         r[c*8 +: 8] = one[7:0];
      end
      return r;
   endfunction

   // ---------------- default build (WIDTH 6, DIGITS 2, NCH 4) ----------------
   logic        d_rst_n = 1'b0;
   logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_busy;
   logic [23:0] d_bin;
   logic [31:0] d_bcd;
   logic [3:0]  d_ovf;

   seq_bin2bcd_multi u_dut (
      .clk(clk), .rst_n(d_rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
      .bin_in(d_bin), .out_valid(d_out_valid), .out_ready(d_out_ready),
      .bcd_out(d_bcd), .ovf(d_ovf), .busy(d_busy)
   );

   // ---------------- overflow builds (WIDTH 7, DIGITS 2, NCH 2) ----------------
   logic        r_rst_n = 1'b0;
   logic        o_in_valid, o_out_ready;
   logic [13:0] o_bin;
   logic        o0_in_ready, o0_out_valid, o0_busy, o1_in_ready, o1_out_valid, o1_busy;
   logic [15:0] o0_bcd, o1_bcd;
   logic [1:0]  o0_ovf, o1_ovf;

   seq_bin2bcd_multi #(.WIDTH(7), .DIGITS(2), .NCH(2), .SATURATE(0)) u_ovf0 (
      .clk(clk), .rst_n(r_rst_n), .in_valid(o_in_valid), .in_ready(o0_in_ready),
      .bin_in(o_bin), .out_valid(o0_out_valid), .out_ready(o_out_ready),
      .bcd_out(o0_bcd), .ovf(o0_ovf), .busy(o0_busy)
   );

   seq_bin2bcd_multi #(.WIDTH(7), .DIGITS(2), .NCH(2), .SATURATE(1)) u_ovf1 (
      .clk(clk), .rst_n(r_rst_n), .in_valid(o_in_valid), .in_ready(o1_in_ready),
      .bin_in(o_bin), .out_valid(o1_out_valid), .out_ready(o_out_ready),
      .bcd_out(o1_bcd), .ovf(o1_ovf), .busy(o1_busy)
   );

   // ---------------- randomized builds ----------------
   localparam int unsigned NCFG = 7;
   localparam int unsigned NT   = 72;

   // fields: 0 = NCH, 1 = WIDTH, 2 = DIGITS, 3 = SATURATE
   function automatic int unsigned cfg_val(input int unsigned i, input int unsigned f);
      logic [31:0] p;
      case (i)
         0:       p = {8'd1, 8'd1,  8'd1, 8'd0};
         1:       p = {8'd3, 8'd5,  8'd2, 8'd0};
         2:       p = {8'd4, 8'd10, 8'd4, 8'd0};
         3:       p = {8'd3, 8'd10, 8'd2, 8'd1};
         4:       p = {8'd1, 8'd6,  8'd1, 8'd0};
         5:       p = {8'd4, 8'd6,  8'd1, 8'd1};
         default: p = {8'd3, 8'd1,  8'd4, 8'd0};
      endcase
      return int'(p[(3-f)*8 +: 8]);
   endfunction

   for (genvar g = 0; g < NCFG; g++) begin : g_rand
      localparam int unsigned N = cfg_val(g, 0);
      localparam int unsigned W = cfg_val(g, 1);
      localparam int unsigned D = cfg_val(g, 2);
      localparam int unsigned S = cfg_val(g, 3);

      logic               in_valid, in_ready, out_valid, out_ready, busy;
      logic [N*W-1:0]     bin;
      logic [N*D*4-1:0]   bcd;
      logic [N-1:0]       ovf;

      seq_bin2bcd_multi #(.WIDTH(W), .DIGITS(D), .NCH(N), .SATURATE(S)) u_dut (
         .clk(clk), .rst_n(r_rst_n), .in_valid(in_valid), .in_ready(in_ready),
         .bin_in(bin), .out_valid(out_valid), .out_ready(out_ready),
         .bcd_out(bcd), .ovf(ovf), .busy(busy)
      );

      // Random transactions with boundary values mixed in, checked against ref_chan
      initial begin : stim
         longint unsigned v, maxv, lim;
         logic [63:0] exp_bcd, exp_ovf, one;
         int          lat, w;
         bit          early;
         in_valid  = 1'b0;
         out_ready = 1'b0;
         bin       = '0;
         maxv      = (64'd1 << W) - 1;
         lim       = 1;
         for (int i = 0; i < int'(D); i++) lim = lim * 10;
         @(posedge r_rst_n);
         @(negedge clk);
         for (int t = 0; t < int'(NT); t++) begin
            exp_bcd = '0;
            exp_ovf = '0;
            for (int c = 0; c < int'(N); c++) begin
               case ($urandom_range(0, 3))
                  0:       v = maxv;
                  1:       v = ((lim - 1) < maxv) ? (lim - 1 + 64'($urandom_range(0, 1))) : maxv;
                  default: v = 64'($urandom) % (maxv + 1);
               endcase
               bin[c*W +: W] = W'(v);
               one     = ref_chan(v, D, S != 0);
               exp_bcd = exp_bcd | (one << (c*D*4));
               exp_ovf[c] = (v > lim - 1);
            end
            early     = 1'($urandom_range(0, 1));
            out_ready = early;
            in_valid  = 1'b1;
            w = 0;
            while (!in_ready && w < 500) begin
               @(negedge clk);
               w++;
            end
            check_eq($sformatf("r%0d accept", g), 64'(in_ready), 64'd1);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            bin      = ~bin;
            lat = 0;
            while (!out_valid && lat < 2000) begin
               @(posedge clk);
               lat++;
               @(negedge clk);
            end
            check_eq($sformatf("r%0d latency", g), 64'(lat), 64'(N*W));
            check_eq($sformatf("r%0d bcd", g), 64'(bcd), exp_bcd);
            check_eq($sformatf("r%0d ovf", g), 64'(ovf), exp_ovf);
            if (!early) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               out_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            check_eq($sformatf("r%0d valid_drop", g), 64'(out_valid), 64'd0);
         end
         done_cnt++;
      end
   end

   // ---------------- directed helpers ----------------
   task automatic d_accept(input logic [23:0] b);
      int w = 0;
      d_bin      = b;
      d_in_valid = 1'b1;
      while (!d_in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check_eq("d_accept_ready", 64'(d_in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      d_in_valid = 1'b0;
      d_bin      = ~b;
   endtask

   task automatic d_wait_done(output int lat);
      lat = 0;
      while (!d_out_valid && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic d_release();
      d_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d_out_ready = 1'b0;
      check_eq("rel_valid", 64'(d_out_valid), 64'd0);
      check_eq("rel_ready", 64'(d_in_ready), 64'd1);
      check_eq("rel_busy", 64'(d_busy), 64'd0);
   endtask

   task automatic o_txn(input logic [13:0] b, input logic [15:0] e0, input logic [15:0] e1,
                        input logic [1:0] eo);
      int w = 0;
      o_bin      = b;
      o_in_valid = 1'b1;
      while (!o0_in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check_eq("o_accept_ready", 64'(o0_in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      o_in_valid = 1'b0;
      w = 0;
      while (!o0_out_valid && w < 100) begin
         @(negedge clk);
         w++;
      end
      check_eq("o_valid0", 64'(o0_out_valid), 64'd1);
      check_eq("o_valid1", 64'(o1_out_valid), 64'd1);
      check_eq("o_bcd_mod", 64'(o0_bcd), 64'(e0));
      check_eq("o_bcd_sat", 64'(o1_bcd), 64'(e1));
      check_eq("o_ovf_mod", 64'(o0_ovf), 64'(eo));
      check_eq("o_ovf_sat", 64'(o1_ovf), 64'(eo));
      o_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      o_out_ready = 1'b0;
   endtask

   // Safety net in case a wait escapes its bound
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, n_tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int          lat, w;
      int unsigned acc [4];
      logic [23:0] bv  [4];
      d_in_valid  = 1'b0;
      d_out_ready = 1'b0;
      d_bin       = '0;
      o_in_valid  = 1'b0;
      o_out_ready = 1'b0;
      o_bin       = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_in_ready", 64'(d_in_ready), 64'd1);
      check_eq("rst_out_valid", 64'(d_out_valid), 64'd0);
      check_eq("rst_busy", 64'(d_busy), 64'd0);
      check_eq("rst_bcd", 64'(d_bcd), 64'd0);
      check_eq("rst_ovf", 64'(d_ovf), 64'd0);
      d_rst_n = 1'b1;
      r_rst_n = 1'b1;
      @(negedge clk);

      // Default example
      d_accept({6'd23, 6'd59, 6'd0, 6'd7});
      check_eq("conv_busy", 64'(d_busy), 64'd1);
      check_eq("conv_in_ready", 64'(d_in_ready), 64'd0);
      d_wait_done(lat);
      check_eq("t1_latency", 64'(lat), 64'd24);
      check_eq("t1_bcd", 64'(d_bcd), 64'h2359_0007);
      check_eq("t1_ovf", 64'(d_ovf), 64'd0);
      d_release();

      // Boundaries, then backpressure with a competing request
      d_accept({6'd63, 6'd9, 6'd10, 6'd59});
      d_wait_done(lat);
      check_eq("t2_latency", 64'(lat), 64'd24);
      check_eq("t2_bcd", 64'(d_bcd), 64'h6309_1059);
      check_eq("t2_ovf", 64'(d_ovf), 64'd0);
      d_in_valid = 1'b1;
      d_bin      = {6'd1, 6'd2, 6'd3, 6'd4};
      repeat (10) begin
         @(negedge clk);
         check_eq("bp_valid", 64'(d_out_valid), 64'd1);
         check_eq("bp_bcd", 64'(d_bcd), 64'h6309_1059);
         check_eq("bp_ovf", 64'(d_ovf), 64'd0);
         check_eq("bp_in_ready", 64'(d_in_ready), 64'd0);
      end
      d_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d_out_ready = 1'b0;
      check_eq("bp_rel_valid", 64'(d_out_valid), 64'd0);
      check_eq("bp_rel_ready", 64'(d_in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      d_in_valid = 1'b0;
      d_bin      = '0;
      check_eq("bp_next_busy", 64'(d_busy), 64'd1);
      d_wait_done(lat);
      check_eq("bp_next_latency", 64'(lat), 64'd24);
      check_eq("bp_next_bcd", 64'(d_bcd), 64'h0102_0304);
      d_release();

      // Asynchronous reset in the middle of a conversion
      d_accept({6'd45, 6'd12, 6'd33, 6'd1});
      repeat (5) @(posedge clk);
      #2 d_rst_n = 1'b0;
      #1;
      check_eq("arst_valid", 64'(d_out_valid), 64'd0);
      check_eq("arst_busy", 64'(d_busy), 64'd0);
      check_eq("arst_in_ready", 64'(d_in_ready), 64'd1);
      check_eq("arst_bcd", 64'(d_bcd), 64'd0);
      check_eq("arst_ovf", 64'(d_ovf), 64'd0);
      @(negedge clk);
      d_rst_n = 1'b1;
      @(negedge clk);
      d_accept({6'd45, 6'd12, 6'd33, 6'd1});
      d_wait_done(lat);
      check_eq("arst_next_latency", 64'(lat), 64'd24);
      check_eq("arst_next_bcd", 64'(d_bcd), 64'h4512_3301);
      d_release();

      // Back-to-back with both handshakes held high
      for (int k = 0; k < 4; k++) bv[k] = 24'($urandom);
      d_out_ready = 1'b1;
      d_in_valid  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         d_bin = bv[k];
         w = 0;
         while (!d_in_ready && w < 100) begin
            @(negedge clk);
            w++;
         end
         acc[k] = cyc + 1;
         @(posedge clk);
         @(negedge clk);
         if (k == 3) d_in_valid = 1'b0;
         w = 0;
         while (!d_out_valid && w < 100) begin
            @(negedge clk);
            w++;
         end
         check_eq("b2b_bcd", 64'(d_bcd), 64'(exp_default(bv[k])));
         if (k > 0) check_eq("b2b_period", 64'(acc[k] - acc[k-1]), 64'd26);
      end
      @(negedge clk);
      d_out_ready = 1'b0;

      // Overflow, with and without saturation
      o_txn({7'd127, 7'd100}, 16'h2700, 16'h9999, 2'b11);
      o_txn({7'd99, 7'd0},    16'h9900, 16'h9900, 2'b00);
      o_txn({7'd100, 7'd99},  16'h0099, 16'h9999, 2'b10);

      w = 0;
      while (done_cnt < NCFG && w < 20000) begin
         @(negedge clk);
         w++;
      end
      check_eq("rand_done", 64'(done_cnt), 64'(NCFG));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
